// File: rtl/sdadc_pkg.sv
// rtl/sdadc_pkg.sv - shared constants, coefficient table and arithmetic helpers for the CIC compensator
//
// Purpose: single source for the sample/coefficient/accumulator widths, the 16 unique
// Q1.17 compensation coefficients (symmetric 32-tap filter, unity DC gain), and the
// saturation and rounding helpers used by the FIR datapath.
package sdadc_pkg;

    localparam int IN_W   = 50;
    localparam int SMP_W  = 24;
    localparam int SHIFT  = 26;
    localparam int COEF_W = 18;
    localparam int NTAPS  = 32;
    localparam int NUNIQ  = NTAPS / 2;
    localparam int DECIM  = 2;
    localparam int ACC_W  = 48;
    localparam int DEPTH  = 2 * NTAPS;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int K_W    = $clog2(NUNIQ);
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PRE_W  = SMP_W + 1;
    localparam int FRAC_W = COEF_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    // h[0] is the outermost tap pair, h[NUNIQ-1] the centre pair.
    // Sum over all 32 taps is exactly 2^17, so DC passes with unity gain.
    localparam logic signed [COEF_W-1:0] COEF [NUNIQ] = '{
        -18'sd64,   -18'sd160,  -18'sd96,   18'sd192,
         18'sd512,   18'sd480,  -18'sd256, -18'sd1280,
        -18'sd1792, -18'sd256,   18'sd3072, 18'sd5120,
         18'sd2048, -18'sd4096,  18'sd16384, 18'sd45728
    };

    localparam logic signed [IN_W-1:0] SMP_MAX =
        {{(IN_W-SMP_W+1){1'b0}}, {(SMP_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SMP_MIN =
        {{(IN_W-SMP_W+1){1'b1}}, {(SMP_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND_HALF =
        {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // Clamp a wide signed value into the SMP_W signed range.
    function automatic logic [SMP_W-1:0] sat_smp(input logic signed [IN_W-1:0] v);
        if (v > SMP_MAX)
            return SMP_MAX[SMP_W-1:0];
        else if (v < SMP_MIN)
            return SMP_MIN[SMP_W-1:0];
        else
            return v[SMP_W-1:0];
    endfunction

    // Drop the Q1.17 fraction with round-half-up.
    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        return (a + RND_HALF) >>> FRAC_W;
    endfunction

endpackage

// File: rtl/cic_comp_fir_coef_rom.sv
// rtl/cic_comp_fir_coef_rom.sv - registered coefficient lookup for the compensation FIR
//
// Purpose: returns h[addr_i] one clock after the address is presented.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   addr_i  in   unique-coefficient index k
//   coef_o  out  registered signed Q1.17 coefficient h[k]
module cic_comp_fir_coef_rom
    import sdadc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [K_W-1:0]           addr_i,
    output logic signed [COEF_W-1:0] coef_o
);

    logic signed [COEF_W-1:0] coef_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            coef_q <= '0;
        else
            coef_q <= COEF[addr_i];
    end

    assign coef_o = coef_q;

endmodule

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - decimate-by-2 symmetric 32-tap CIC droop-compensation FIR
//
// Purpose: scales/saturates each CIC sample to 24 bits into a 64-deep circular buffer,
// and on every second sample runs a 16-cycle folded MAC followed by a rounding output cycle.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   data_in     in   signed CIC sample, qualified by data_valid
//   data_valid  in   one-cycle input strobe, accepted in any state
//   data_out    out  signed filtered sample, held between strobes
//   out_valid   out  one-cycle strobe with each new data_out
//   busy        out  high while a computation is in flight
//   overrun     out  sticky flag: a trigger arrived while busy and was dropped
module cic_comp_fir
    import sdadc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  data_in,
    input  logic             data_valid,
    output logic [SMP_W-1:0] data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam logic [K_W-1:0]  K_LAST    = K_W'(NUNIQ - 1);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(DECIM - 1);
    localparam logic [PTR_W-1:0] FAR_OFFS = PTR_W'(NTAPS - 1);

    fir_state_e        state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  base_q;
    logic [PH_W-1:0]   phase_q;
    logic [K_W-1:0]    k_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [SMP_W-1:0]  ram_q [DEPTH];
    logic [SMP_W-1:0]  data_out_q;
    logic              out_valid_q;
    logic              overrun_q;

    // Input scaling
    logic signed [IN_W-1:0] din_sh;
    logic [SMP_W-1:0]       x_d;
    logic                   trigger;

    assign din_sh  = $signed(data_in) >>> SHIFT;
    assign x_d     = sat_smp(din_sh);
    assign trigger = data_valid && (phase_q == PH_LAST);

    // Coefficient fetch runs one index ahead of the MAC; in IDLE it parks on h[0]
    // so the first MAC cycle already has its coefficient.
    logic [K_W-1:0]           rom_addr;
    logic signed [COEF_W-1:0] coef;

    assign rom_addr = (state_q == ST_MAC) ? k_q + K_W'(1) : '0;

    cic_comp_fir_coef_rom u_coef_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_i (rom_addr),
        .coef_o (coef)
    );

    // Folded tap pair: newest-k and oldest-k samples share h[k]. Reads are relative to
    // the latched base, so new writes (landing at base+1 onward) never reach base-31..base.
    logic [PTR_W-1:0]        idx_a, idx_b;
    logic [SMP_W-1:0]        tap_a, tap_b;
    logic signed [PRE_W-1:0] pre_sum;
    logic signed [ACC_W-1:0] pre_ext, coef_ext, prod;
    logic signed [ACC_W-1:0] rnd;
    logic [SMP_W-1:0]        out_d;

    assign idx_a    = base_q - PTR_W'(k_q);
    assign idx_b    = base_q - FAR_OFFS + PTR_W'(k_q);
    assign tap_a    = ram_q[idx_a];
    assign tap_b    = ram_q[idx_b];
    assign pre_sum  = $signed({tap_a[SMP_W-1], tap_a}) + $signed({tap_b[SMP_W-1], tap_b});
    assign pre_ext  = {{(ACC_W-PRE_W){pre_sum[PRE_W-1]}}, pre_sum};
    assign coef_ext = {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};
    assign prod     = pre_ext * coef_ext;
    assign rnd      = round_shift(acc_q);
    assign out_d    = sat_smp({{(IN_W-ACC_W){rnd[ACC_W-1]}}, rnd});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            phase_q     <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                ram_q[i] <= '0;
        end else begin
            out_valid_q <= 1'b0;

            // Samples are always captured, whatever the FSM is doing.
            if (data_valid) begin
                ram_q[wr_ptr_q] <= x_d;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                phase_q         <= (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            end

            // Includes the OUT cycle: the FSM is not yet back in IDLE there.
            if (trigger && (state_q != ST_IDLE))
                overrun_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        base_q  <= wr_ptr_q;
                        k_q     <= '0;
                        acc_q   <= '0;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_q + prod;
                    k_q   <= k_q + K_W'(1);
                    if (k_q == K_LAST)
                        state_q <= ST_OUT;
                end
                ST_OUT: begin
                    data_out_q  <= out_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb/tb_cic_comp_fir.sv - self-checking bench for cic_comp_fir against a direct-convolution model
module tb_cic_comp_fir;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [49:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic [23:0] data_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    cic_comp_fir dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    longint edge_n = 0;

    always @(posedge clk) edge_n = edge_n + 1;

    localparam int H16 [16] = '{
        -64, -160, -96, 192, 512, 480, -256, -1280,
        -1792, -256, 3072, 5120, 2048, -4096, 16384, 45728
    };
    localparam longint NEVER = 64'sh7fff_ffff_ffff_ffff;

    typedef struct {
        logic [23:0] y;
        longint      e;
    } exp_t;

    int          hist[$];
    exp_t        exp_q[$];
    int          smp_cnt;
    int          out_cnt;
    longint      free_edge;
    longint      ovr_edge;
    logic [23:0] last_out;
    exp_t        mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int htap(input int t);
        return (t < 16) ? H16[t] : H16[31 - t];
    endfunction

    function automatic longint clamp24(input longint v);
        if (v > 8388607)  return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    // Full 32-tap convolution over the sample history; anything before reset is zero.
    function automatic logic [23:0] ref_y();
        longint acc = 0;
        longint r;
        int n = hist.size();
        for (int t = 0; t < 32; t++) begin
            int idx = n - 1 - t;
            if (idx >= 0)
                acc += longint'(htap(t)) * longint'(hist[idx]);
        end
        r = clamp24((acc + 65536) >>> 17);
        return r[23:0];
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        smp_cnt   = 0;
        out_cnt   = 0;
        free_edge = 0;
        ovr_edge  = NEVER;
        last_out  = '0;
    endtask

    // Sample accepted at clock edge e; every 2nd sample is a trigger, which the filter
    // takes only if the previous computation (18-clock window) has finished.
    task automatic push_sample(input logic [49:0] d, input longint e);
        longint v;
        exp_t   x;
        v = clamp24(longint'($signed(d)) >>> 26);
        hist.push_back(int'(v));
        smp_cnt++;
        if (smp_cnt % 2 == 0) begin
            if (e >= free_edge) begin
                x.y = ref_y();
                x.e = e + 17;
                exp_q.push_back(x);
                free_edge = e + 18;
            end else if (ovr_edge == NEVER) begin
                ovr_edge = e;
            end
        end
    endtask

    function automatic logic [49:0] rand50();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[49:0];
    endfunction

    task automatic send(input logic [49:0] d, input int gap);
        @(negedge clk);
        data_valid = 1'b1;
        data_in    = d;
        push_sample(d, edge_n + 1);
        for (int i = 1; i < gap; i++) begin
            @(negedge clk);
            data_valid = 1'b0;
            data_in    = rand50();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        data_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                out_cnt++;
                chk("out_expected", 64'(exp_q.size() != 0), 64'(1'b1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("dout", 64'(data_out), 64'(mon_e.y));
                    chk("latency", 64'(edge_n), 64'(mon_e.e));
                end
                chk("busy_at_out", 64'(busy), 64'(1'b0));
                chk("ovr_at_out", 64'(overrun), 64'(edge_n >= ovr_edge));
                last_out = data_out;
            end else begin
                chk("hold", 64'(data_out), 64'(last_out));
            end
        end
    end

    logic [49:0] v;

    initial begin
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_dout", 64'(data_out), 64'(0));
        chk("rst_oval", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ovr", 64'(overrun), 64'(0));
        rst = 1'b0;

        // Reset in the middle of a MAC, then a fresh computation from zeroed RAM
        send(rand50(), 9);
        send(rand50(), 9);
        chk("busy_mid", 64'(busy), 64'(1'b1));
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_oval", 64'(out_valid), 64'(0));
        chk("mid_rst_dout", 64'(data_out), 64'(0));
        chk("mid_rst_ovr", 64'(overrun), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        send(rand50(), 9);
        send(rand50(), 9);
        idle(25);
        chk("post_rst_cnt", 64'(out_cnt), 64'(1));

        // DC at one sample per 8 clocks
        do_reset();
        v = 50'd1000 << 26;
        for (int i = 0; i < 40; i++) send(v, 8);
        idle(30);
        chk("dc_value", 64'(data_out), 64'(24'd1000));
        chk("dc_ovr", 64'(overrun), 64'(1'b1));

        // Impulse response
        do_reset();
        v = 50'd4096 << 26;
        send(v, 9);
        for (int i = 0; i < 39; i++) send('0, 9);
        idle(30);
        chk("imp_cnt", 64'(out_cnt), 64'(20));
        chk("imp_tail", 64'(data_out), 64'(0));

        // Saturated full scale, both polarities
        do_reset();
        v = {1'b0, {49{1'b1}}};
        for (int i = 0; i < 40; i++) send(v, 9);
        idle(30);
        chk("sat_pos", 64'(data_out), 64'(24'h7fffff));
        v = {1'b1, 49'd0};
        for (int i = 0; i < 40; i++) send(v, 9);
        idle(30);
        chk("sat_neg", 64'(data_out), 64'(24'h800000));

        // Back-to-back input: overrun from the 2nd trigger onward
        do_reset();
        send(rand50(), 1);
        send(rand50(), 1);
        send(rand50(), 1);
        chk("ovr_first", 64'(overrun), 64'(1'b0));
        send(rand50(), 1);
        send(rand50(), 1);
        chk("ovr_second", 64'(overrun), 64'(1'b1));
        for (int i = 0; i < 35; i++) send(rand50(), 1);
        idle(40);
        chk("ovr_sticky", 64'(overrun), 64'(1'b1));
        chk("ovr_cnt", 64'(out_cnt), 64'(3));

        // Random samples at 1-in-9 across several pointer wraps
        do_reset();
        for (int i = 0; i < 220; i++) send(rand50(), 9);
        idle(30);
        chk("rnd_ovr", 64'(overrun), 64'(1'b0));
        chk("rnd_cnt", 64'(out_cnt), 64'(110));

        chk("drain", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
